// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider (div_seq).
// Holds the FSM state encoding and the divide-by-zero quotient pattern.
package div_pkg;

  // Controller states; encodings are fixed so checkers can decode state_dbg.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Quotient reported on divide-by-zero: all ones, sliced to the datapath width.
  localparam logic [63:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration, purely combinational.
// Shifts {rem,quo} left by one, trial-subtracts the divisor and either keeps
// the difference (quotient bit 1) or restores the shifted remainder (bit 0).
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH_D = 4
) (
  input  logic [WIDTH_D:0]   rem_in,
  input  logic [WIDTH_D-1:0] quo_in,
  input  logic [WIDTH_D-1:0] divisor,
  output logic [WIDTH_D:0]   rem_out,
  output logic [WIDTH_D-1:0] quo_out
);

  logic [WIDTH_D+1:0] rem_sh;
  logic [WIDTH_D:0]   diff;
  logic               fits;

  // Shift, trial-subtract, then select difference or restore.
  always_comb begin
    rem_sh = {rem_in, quo_in[WIDTH_D-1]};
    fits   = (rem_sh >= {2'b00, divisor});
    diff   = rem_sh[WIDTH_D:0] - {1'b0, divisor};
    if (fits) begin
      rem_out = diff;
      quo_out = {quo_in[WIDTH_D-2:0], 1'b1};
    end else begin
      rem_out = rem_sh[WIDTH_D:0];
      quo_out = {quo_in[WIDTH_D-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_seq.sv
// Sequential restoring divider: one quotient bit per clock in CALC.
// Optional feature macro DIV_SIGNED_EN: two's complement operands, the core
// divides magnitudes and the result is sign-corrected (truncation toward zero,
// remainder takes the dividend's sign). Without it everything is unsigned.
//
// Handshake: start is sampled on every rising edge but only accepted in IDLE
// or DONE (busy=0); operands are captured on the accepting edge. While busy=1
// start is ignored. done is high for the single cycle the FSM sits in DONE and
// quotient/remainder/div_by_zero are valid from then until the next result.
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH_D = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH_D-1:0] dividend,
  input  logic [WIDTH_D-1:0] divisor,
  output logic               busy,
  output logic               done,
  output logic [WIDTH_D-1:0] quotient,
  output logic [WIDTH_D-1:0] remainder,
  output logic               div_by_zero,
  output state_t             state_dbg
);

  localparam int CNT_W = $clog2(WIDTH_D + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH_D - 1);

  state_t             state;
  state_t             state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH_D:0]   rem_w;
  logic [WIDTH_D-1:0] quo_w;
  logic [WIDTH_D-1:0] dsr_w;
  logic [WIDTH_D:0]   rem_nx;
  logic [WIDTH_D-1:0] quo_nx;
  logic               accept;
  logic               zero_div;
  logic               last_step;
  logic [WIDTH_D-1:0] a_mag;
  logic [WIDTH_D-1:0] b_mag;
  logic [WIDTH_D-1:0] q_fix;
  logic [WIDTH_D-1:0] r_fix;

  assign state_dbg = state;
  assign zero_div  = (divisor == '0);
  assign last_step = (cnt == CNT_LAST);

  div_step #(
    .WIDTH_D (WIDTH_D)
  ) u_step (
    .rem_in  (rem_w),
    .quo_in  (quo_w),
    .divisor (dsr_w),
    .rem_out (rem_nx),
    .quo_out (quo_nx)
  );

`ifdef DIV_SIGNED_EN
  logic sgn_q;
  logic sgn_r;

  // Operand magnitudes on the way in, sign correction on the way out.
  always_comb begin
    a_mag = dividend[WIDTH_D-1] ? -dividend : dividend;
    b_mag = divisor[WIDTH_D-1]  ? -divisor  : divisor;
    q_fix = sgn_q ? -quo_nx : quo_nx;
    r_fix = sgn_r ? -rem_nx[WIDTH_D-1:0] : rem_nx[WIDTH_D-1:0];
  end

  // Remember the result signs for the operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      sgn_q <= 1'b0;
      sgn_r <= 1'b0;
    end else if (accept) begin
      sgn_q <= dividend[WIDTH_D-1] ^ divisor[WIDTH_D-1];
      sgn_r <= dividend[WIDTH_D-1];
    end
  end
`else
  // Unsigned build: operands and results pass straight through.
  always_comb begin
    a_mag = dividend;
    b_mag = divisor;
    q_fix = quo_nx;
    r_fix = rem_nx[WIDTH_D-1:0];
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and status decode; zero divisor bypasses CALC entirely.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = zero_div ? DONE : CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (last_step) state_nx = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept   = 1'b1;
          state_nx = zero_div ? DONE : CALC;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Working registers, iteration counter and held result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      rem_w       <= '0;
      quo_w       <= '0;
      dsr_w       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      cnt   <= '0;
      rem_w <= '0;
      quo_w <= a_mag;
      dsr_w <= b_mag;
      if (zero_div) begin
        quotient    <= DBZ_QUOTIENT[WIDTH_D-1:0];
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end
    end else if (state == CALC) begin
      cnt   <= cnt + CNT_W'(1);
      rem_w <= rem_nx;
      quo_w <= quo_nx;
      if (last_step) begin
        quotient    <= q_fix;
        remainder   <= r_fix;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 The module SHALL have parameter WIDTH_D, default 4, giving the dividend, divisor, quotient and remainder width in bits.
REQ-002 The module SHALL have local parameter CNT_W, equal to clog2(WIDTH_D+1), giving the iteration counter width.
REQ-003 clk  input  1  The module SHALL use this single clock; all state updates occur on the rising edge.
REQ-004 rst  input  1  The module SHALL use this synchronous, active-high reset.
REQ-005 start  input  1  The module SHALL treat this as a request to begin a division; it is sampled on the rising edge.
REQ-006 dividend  input  WIDTH_D  The module SHALL take this as the dividend operand, captured when start is accepted.
REQ-007 divisor  input  WIDTH_D  The module SHALL take this as the divisor operand, captured when start is accepted.
REQ-008 busy  output  1  The module SHALL drive this high while a division is in progress.
REQ-009 done  output  1  The module SHALL drive this as a one-cycle pulse when results become valid.
REQ-010 quotient  output  WIDTH_D  The module SHALL drive the quotient on this port.
REQ-011 remainder  output  WIDTH_D  The module SHALL drive the remainder on this port.
REQ-012 div_by_zero  output  1  The module SHALL drive this high with done when the divisor is 0.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-014 In IDLE or DONE, start=1 SHALL capture both operands, clear the iteration counter and move to CALC.
REQ-015 If start=1 and divisor==0 in IDLE or DONE, the FSM SHALL skip CALC and go straight to DONE.
REQ-016 In CALC, each cycle SHALL perform one restoring step: shift {rem,quo} left by 1, trial-subtract the divisor, set the quotient LSB to 1 if the result is non-negative, otherwise restore.
REQ-017 After exactly WIDTH_D CALC cycles, the FSM SHALL enter DONE.
REQ-018 Latency: done SHALL be high for exactly one cycle, WIDTH_D+1 cycles after the start edge; for divide-by-zero, 1 cycle after the start edge.
REQ-019 busy SHALL be 1 in CALC only, and done SHALL be 1 in DONE only.
REQ-020 From DONE, the FSM SHALL return to IDLE unless start=1, so that back-to-back operations are accepted.
REQ-021 quotient, remainder and div_by_zero SHALL hold their last values until the next operation reaches DONE.
REQ-022 A start asserted while busy=1 SHALL be ignored with no effect on the operation in flight.
REQ-023 Divide-by-zero result: quotient SHALL be all ones, remainder SHALL be the dividend, and div_by_zero SHALL be 1.
REQ-024 For all non-zero divisors, the results SHALL satisfy dividend = quotient*divisor + remainder, with remainder < divisor.
REQ-025 The internal partial remainder SHALL be WIDTH_D+1 bits wide, and no result bit SHALL be truncated.

Reset
REQ-026 When rst=1 at a clock edge, state SHALL go to IDLE and busy, done, quotient, remainder, div_by_zero and the counter SHALL all go to 0.
REQ-027 Reset asserted during CALC SHALL abort the operation, and done SHALL NOT be asserted for that operation.

Configuration
REQ-028 With DIV_SIGNED_EN defined, operands SHALL be two's complement and the core SHALL divide their magnitudes.
REQ-029 With DIV_SIGNED_EN defined, the quotient SHALL be negated if the operand signs differ, giving truncation toward zero.
REQ-030 With DIV_SIGNED_EN defined, the remainder SHALL take the sign of the dividend.
REQ-031 With DIV_SIGNED_EN defined, the most-negative dividend divided by -1 SHALL give quotient equal to the most-negative value and remainder 0.
REQ-032 With DIV_SIGNED_EN defined, the divide-by-zero result SHALL be as in REQ-023, and latency SHALL be unchanged.
REQ-033 Without DIV_SIGNED_EN, all operands SHALL be treated as unsigned and no sign logic SHALL be present.

Structure
REQ-034 Package div_pkg SHALL hold the FSM state encodings (IDLE=2'd0, CALC=2'd1, DONE=2'd2) and the divide-by-zero quotient constant.
REQ-035 Sub-module div_step SHALL be combinational, performing one restoring iteration (inputs: partial remainder, quotient, divisor; outputs: next partial remainder, next quotient).
REQ-036 div_seq SHALL instantiate div_step once.

Verification (WIDTH_D=4)
REQ-037 The bench SHALL check: unsigned 13/3 -> quotient=4, remainder=1, div_by_zero=0, done exactly 5 cycles after start, busy high for 4 cycles.
REQ-038 The bench SHALL check: 7/0 -> quotient=15, remainder=7, div_by_zero=1, done 1 cycle after start, busy never high.
REQ-039 The bench SHALL run an exhaustive 16x16 sweep with back-to-back starts issued in DONE -> every result matches the golden model, with no idle cycle lost.
REQ-040 The bench SHALL check: start 9/2 held high through CALC -> single result quotient=4, remainder=1; the extra starts are ignored.
REQ-041 The bench SHALL check: start 15/1, then rst=1 on the 2nd CALC cycle -> IDLE with all outputs 0 and no done pulse; a new 6/4 then gives quotient=1, remainder=2.
REQ-042 The bench SHALL check, with DIV_SIGNED_EN defined: -7/2 -> quotient=-3 (4'hD), remainder=-1 (4'hF); -8/-1 -> quotient=4'h8, remainder=0.
